// File: rtl/hazard_unit_sb_if.sv
// Hazard-unit bundle: pipeline-side controls and hazard-unit responses.
// master = pipeline (drives stage info), slave = hazard_unit_sb.
interface hazard_unit_sb_if #(
    parameter int ADDR_W = 5
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [ADDR_W-1:0]   rs1_D, rs2_D, rd_D;
    logic                rs1_used_D, rs2_used_D, regwrite_D, branch_D, md_D;
    logic [ADDR_W-1:0]   rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic                regwrite_E, regwrite_M, regwrite_W;
    logic                memtoreg_E, memtoreg_M, pcsrc_E;
    logic                md_issue_E, md_done_W, md_busy;
    logic                StallF, StallD, FlushD, FlushE;
    logic [1:0]          ForwardAE, ForwardBE, BranchForwardAE, BranchForwardBE;
    logic [NUM_REGS-1:0] sb_pending;

    modport master (
        output rs1_D, rs2_D, rd_D, rs1_used_D, rs2_used_D, regwrite_D, branch_D, md_D,
               rs1_E, rs2_E, rd_E, rd_M, rd_W, regwrite_E, regwrite_M, regwrite_W,
               memtoreg_E, memtoreg_M, pcsrc_E, md_issue_E, md_done_W, md_busy,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               BranchForwardAE, BranchForwardBE, sb_pending
    );

    modport slave (
        input  rs1_D, rs2_D, rd_D, rs1_used_D, rs2_used_D, regwrite_D, branch_D, md_D,
               rs1_E, rs2_E, rd_E, rd_M, rd_W, regwrite_E, regwrite_M, regwrite_W,
               memtoreg_E, memtoreg_M, pcsrc_E, md_issue_E, md_done_W, md_busy,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               BranchForwardAE, BranchForwardBE, sb_pending
    );
endinterface

// File: rtl/hazard_unit_sb.sv
// Hazard unit with MDU pending-write scoreboard for the 5-stage RV64I core.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_unit_sb #(
    parameter int ADDR_W = 5,
    parameter int PERF_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    hazard_unit_sb_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] sb_pending, sb_next, done_mask, pend_eff;
    logic load_use, branch_load, raw_md, waw_md, struct_md, stall_req;

    function automatic logic hit_d(input logic [ADDR_W-1:0] r,
                                   input logic [ADDR_W-1:0] rs1, input logic u1,
                                   input logic [ADDR_W-1:0] rs2, input logic u2);
        return (r != '0) && (((r == rs1) && u1) || ((r == rs2) && u2));
    endfunction

    function automatic logic [1:0] fwd_e(input logic [ADDR_W-1:0] rs,
                                         input logic we_m, input logic [ADDR_W-1:0] rd_m,
                                         input logic we_w, input logic [ADDR_W-1:0] rd_w);
        if (rs == '0)                   return 2'b00;
        else if (we_m && (rd_m == rs))  return 2'b10;
        else if (we_w && (rd_w == rs))  return 2'b01;
        else                            return 2'b00;
    endfunction

    // Youngest producing stage wins; loads in E/M cannot forward (stall covers them).
    function automatic logic [1:0] fwd_d(input logic [ADDR_W-1:0] rs,
                                         input logic we_e, input logic ld_e, input logic [ADDR_W-1:0] rd_e,
                                         input logic we_m, input logic ld_m, input logic [ADDR_W-1:0] rd_m,
                                         input logic we_w, input logic [ADDR_W-1:0] rd_w);
        if (rs == '0)                          return 2'b00;
        else if (we_e && !ld_e && (rd_e == rs)) return 2'b01;
        else if (we_m && !ld_m && (rd_m == rs)) return 2'b10;
        else if (we_w && (rd_w == rs))          return 2'b11;
        else                                    return 2'b00;
    endfunction

    always_comb begin
        done_mask = '0;
        if (hz.md_done_W) done_mask[hz.rd_W] = 1'b1;
        // A result completing in W this cycle is forwarded, so it no longer blocks D.
        pend_eff = sb_pending & ~done_mask;

        load_use    = hz.memtoreg_E & hit_d(hz.rd_E, hz.rs1_D, hz.rs1_used_D, hz.rs2_D, hz.rs2_used_D);
        branch_load = hz.branch_D & hz.memtoreg_M
                      & hit_d(hz.rd_M, hz.rs1_D, hz.rs1_used_D, hz.rs2_D, hz.rs2_used_D);
        raw_md      = (hz.rs1_used_D & pend_eff[hz.rs1_D]) | (hz.rs2_used_D & pend_eff[hz.rs2_D]);
        waw_md      = hz.regwrite_D & pend_eff[hz.rd_D];
        struct_md   = hz.md_D & (hz.md_busy | hz.md_issue_E);
        stall_req   = load_use | branch_load | raw_md | waw_md | struct_md;

        hz.StallF = stall_req & ~hz.pcsrc_E;
        hz.StallD = stall_req & ~hz.pcsrc_E;
        hz.FlushD = hz.pcsrc_E;
        hz.FlushE = hz.pcsrc_E | stall_req;

        hz.ForwardAE = fwd_e(hz.rs1_E, hz.regwrite_M, hz.rd_M, hz.regwrite_W, hz.rd_W);
        hz.ForwardBE = fwd_e(hz.rs2_E, hz.regwrite_M, hz.rd_M, hz.regwrite_W, hz.rd_W);
        hz.BranchForwardAE = fwd_d(hz.rs1_D, hz.regwrite_E, hz.memtoreg_E, hz.rd_E,
                                   hz.regwrite_M, hz.memtoreg_M, hz.rd_M, hz.regwrite_W, hz.rd_W);
        hz.BranchForwardBE = fwd_d(hz.rs2_D, hz.regwrite_E, hz.memtoreg_E, hz.rd_E,
                                   hz.regwrite_M, hz.memtoreg_M, hz.rd_M, hz.regwrite_W, hz.rd_W);
    end

    // Clear is applied first so a same-index issue leaves the new op outstanding.
    always_comb begin
        sb_next = sb_pending & ~done_mask;
        if (hz.md_issue_E && hz.regwrite_E && (hz.rd_E != '0)) sb_next[hz.rd_E] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_pending <= '0;
        else        sb_pending <= sb_next;
    end

    assign hz.sb_pending = sb_pending;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (hz.StallD && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
            if (hz.pcsrc_E && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end
`endif
endmodule
